cva6_hpdcache_wbuf_coalesce: RTL
================================

Name: cva6_hpdcache_wbuf_coalesce

Overview:
- Coalescing write buffer between the HPDcache store pipeline and the memory write channel, sized by the HPDcache WBUF parameters.
- Accepts word-granular write-through stores, merges stores to the same word while an entry is open, and drains entries in allocation order after a configurable idle time or on flush.
- Tracks in-flight writes until acknowledged.
- Exposes a read-hazard lookup so the cache can hold loads that collide with pending writes.

Parameters:
- ENTRIES, 4, number of buffer entries (power of two, ≥2); equals CVA6ConfigWtDcacheWbufDepth.
- PA_WIDTH, 34, physical address width.
- WORD_WIDTH, 32, data word width (bits); byte-enable width is WORD_WIDTH/8.
- TIMECNT_WIDTH, 3, idle counter width; the threshold is 2**TIMECNT_WIDTH-1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- wr_valid_i  in  1  store request valid
- wr_ready_o  out  1  store request accepted
- wr_addr_i  in  PA_WIDTH  store byte address; low log2(WORD_WIDTH/8) bits ignored
- wr_data_i  in  WORD_WIDTH  store data
- wr_be_i  in  WORD_WIDTH/8  byte enables
- flush_i  in  1  pulse: close all open entries
- rd_addr_i  in  PA_WIDTH  hazard lookup address
- rd_hit_o  out  1  comb: a non-FREE entry holds the word rd_addr_i
- mem_req_valid_o  out  1  write request valid
- mem_req_ready_i  in  1  write request accepted
- mem_req_addr_o  out  PA_WIDTH  word-aligned address
- mem_req_data_o  out  WORD_WIDTH  merged data
- mem_req_be_o  out  WORD_WIDTH/8  merged byte enables
- mem_req_id_o  out  log2(ENTRIES)  entry index
- mem_rsp_valid_i  in  1  write acknowledge (always accepted)
- mem_rsp_id_i  in  log2(ENTRIES)  acknowledged entry index
- empty_o  out  1  all entries FREE

Behaviour:
- Entry states: FREE → OPEN → PEND → SENT → FREE.
- Reset: all entries FREE; alloc FIFO empty; timers 0. Outputs: wr_ready_o=1, mem_req_valid_o=0, empty_o=1, rd_hit_o comb (0 after reset). mem_req_addr_o, mem_req_data_o, mem_req_be_o and mem_req_id_o are 0.
- Write accept (wr_valid_i & wr_ready_o):
  - If an OPEN entry matches the word address: bytes with be=1 are overwritten, the entry's be is ORed with wr_be_i, and its timer resets to 0.
  - Otherwise the lowest-index FREE entry is allocated OPEN with timer 0, and its index is pushed to the alloc FIFO.
- wr_ready_o=0 when any of the following holds:
  - flush_i=1;
  - the address matches a PEND or SENT entry (ordering hazard);
  - there is no matching OPEN entry and no FREE entry.
- Timer: each OPEN entry increments its timer every cycle it is not merged. In a cycle where timer==threshold and there is no merge, the entry becomes PEND at the clock edge. If a merge coincides with expiry, the merge wins: the timer resets and the entry stays OPEN.
- Flush: in a cycle with flush_i=1, every OPEN entry becomes PEND at the clock edge. No writes are accepted that cycle.
- Send:
  - mem_req_valid_o=1 iff the alloc FIFO head entry is PEND; the mem_req_* fields come from that entry.
  - Only the head is ever sent (strict allocation order); younger PEND entries wait.
  - On valid&ready the head pops and the entry becomes SENT.
  - valid is held and the fields are stable until ready.
- Ack: a mem_rsp_valid_i whose id names a SENT entry frees that entry at the clock edge. Acks may arrive out of order. An ack for a non-SENT id is ignored.
- Simultaneous ack and allocation: the freed entry is not reusable until the next cycle.
- empty_o=1 iff all entries are FREE.
- Latency, no merges: a write accepted in cycle 0 has timer 0 in cycle 1, reaches threshold in cycle 1+threshold, becomes PEND, and raises mem_req_valid_o in cycle 2+threshold.
- Reset mid-operation: all state is discarded, including SENT entries. Any later acks are ignored.

Optional Feature:
- Macro: CVA6_HPDCACHE_WBUF_FEEDTHROUGH_EN.
- Defined: mem_req_valid_o is also asserted combinationally in the cycle in which the head entry is OPEN and will become PEND (timer==threshold without merge, or flush_i=1). The fields carry the entry's current contents. If accepted that cycle, the entry goes directly OPEN→SENT. This saves one cycle.
- Undefined: mem_req_valid_o depends only on registered state, as described in Behaviour.

Test Plan:
- Write 0x1000 be=0xF data=0xAABBCCDD in cycle 0, threshold 7, ready=1 → mem_req_valid_o in cycle 9 with addr 0x1000, data 0xAABBCCDD, be 0xF, id 0. Ack id 0 → empty_o=1 next cycle.
- Write 0x2000 be=0x1 data=0x11; 3 cycles later write 0x2000 be=0x8 data=0x44000000 → a single request with be=0x9 and data=0x44000011, issued 9 cycles after the second write.
- Fill 4 distinct addresses with ready=0, then present a 5th → wr_ready_o=0. Ack one SENT entry (after ready=1) → the 5th is accepted one cycle after the ack.
- Pulse flush_i with 3 OPEN entries (A,B,C) and ready=1 → requests in order A,B,C, ids 0,1,2. wr_ready_o=0 during the flush cycle.
- With an entry PEND at 0x3000, present a write to 0x3000 → wr_ready_o=0 until its ack frees the entry. rd_addr_i=0x3004 gives rd_hit_o=0; rd_addr_i=0x3000 gives rd_hit_o=1.
- With CVA6_HPDCACHE_WBUF_FEEDTHROUGH_EN defined: repeat the first scenario → mem_req_valid_o in cycle 8. An ack with an unused id 3 has no effect.

Source files
------------

// File: rtl/cva6_hpdcache_wbuf_coalesce_if.sv
// Store-side, memory-side and lookup signals of the coalescing write buffer.
interface cva6_hpdcache_wbuf_coalesce_if #(
  parameter int unsigned ENTRIES    = 4,
  parameter int unsigned PA_WIDTH   = 34,
  parameter int unsigned WORD_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = WORD_WIDTH / 8;
  localparam int unsigned ID_WIDTH = $clog2(ENTRIES);

  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [PA_WIDTH-1:0]   wr_addr_i;
  logic [WORD_WIDTH-1:0] wr_data_i;
  logic [BE_WIDTH-1:0]   wr_be_i;
  logic                  flush_i;
  logic [PA_WIDTH-1:0]   rd_addr_i;
  logic                  rd_hit_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [PA_WIDTH-1:0]   mem_req_addr_o;
  logic [WORD_WIDTH-1:0] mem_req_data_o;
  logic [BE_WIDTH-1:0]   mem_req_be_o;
  logic [ID_WIDTH-1:0]   mem_req_id_o;
  logic                  mem_rsp_valid_i;
  logic [ID_WIDTH-1:0]   mem_rsp_id_i;
  logic                  empty_o;

  // Buffer side.
  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, flush_i, rd_addr_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_id_i,
    output wr_ready_o, rd_hit_o, mem_req_valid_o, mem_req_addr_o,
           mem_req_data_o, mem_req_be_o, mem_req_id_o, empty_o
  );

  // Cache / memory side.
  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, flush_i, rd_addr_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_id_i,
    input  wr_ready_o, rd_hit_o, mem_req_valid_o, mem_req_addr_o,
           mem_req_data_o, mem_req_be_o, mem_req_id_o, empty_o
  );
endinterface

// File: rtl/cva6_hpdcache_wbuf_coalesce.sv
// Coalescing write buffer: merges word stores while an entry is open, drains
// entries strictly in allocation order, and tracks them until acknowledged.
// Optional macro CVA6_HPDCACHE_WBUF_FEEDTHROUGH_EN lets an expiring head entry
// be offered to memory in the same cycle it closes.
module cva6_hpdcache_wbuf_coalesce #(
  parameter int unsigned ENTRIES       = 4,
  parameter int unsigned PA_WIDTH      = 34,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned TIMECNT_WIDTH = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  cva6_hpdcache_wbuf_coalesce_if.slave bus
);
  localparam int unsigned BE_WIDTH  = WORD_WIDTH / 8;
  localparam int unsigned ID_WIDTH  = $clog2(ENTRIES);
  localparam int unsigned CNT_WIDTH = ID_WIDTH + 1;
  localparam int unsigned OFF_WIDTH = $clog2(BE_WIDTH);
  localparam int unsigned WA_WIDTH  = PA_WIDTH - OFF_WIDTH;
  localparam logic [TIMECNT_WIDTH-1:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {ST_FREE, ST_OPEN, ST_PEND, ST_SENT} state_e;

  state_e                   state_q [ENTRIES];
  state_e                   state_d [ENTRIES];
  logic [WA_WIDTH-1:0]      addr_q  [ENTRIES];
  logic [WA_WIDTH-1:0]      addr_d  [ENTRIES];
  logic [WORD_WIDTH-1:0]    data_q  [ENTRIES];
  logic [WORD_WIDTH-1:0]    data_d  [ENTRIES];
  logic [BE_WIDTH-1:0]      be_q    [ENTRIES];
  logic [BE_WIDTH-1:0]      be_d    [ENTRIES];
  logic [TIMECNT_WIDTH-1:0] timer_q [ENTRIES];
  logic [TIMECNT_WIDTH-1:0] timer_d [ENTRIES];
  logic [ID_WIDTH-1:0]      fifo_q  [ENTRIES];
  logic [ID_WIDTH-1:0]      head_q, tail_q;
  logic [CNT_WIDTH-1:0]     count_q;

  logic [WA_WIDTH-1:0] wr_word, rd_word;
  logic [ENTRIES-1:0]  open_hit, expire;
  logic                hazard, rd_hit, all_free, free_found;
  logic [ID_WIDTH-1:0] free_idx, head_idx;
  logic                wr_ready, accept, alloc, req_valid, fire;
  logic                unused_addr_bits;

  function automatic logic [WORD_WIDTH-1:0] merge_bytes(
    input logic [WORD_WIDTH-1:0] old_w,
    input logic [WORD_WIDTH-1:0] new_w,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [WORD_WIDTH-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign wr_word = bus.wr_addr_i[PA_WIDTH-1:OFF_WIDTH];
  assign rd_word = bus.rd_addr_i[PA_WIDTH-1:OFF_WIDTH];
  assign unused_addr_bits = ^{bus.wr_addr_i[OFF_WIDTH-1:0], bus.rd_addr_i[OFF_WIDTH-1:0]};

  // Address lookup against all entries: merge target, ordering hazard, load hazard, free slot.
  always_comb begin
    open_hit   = '0;
    hazard     = 1'b0;
    rd_hit     = 1'b0;
    all_free   = 1'b1;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (state_q[i] == ST_OPEN && addr_q[i] == wr_word) open_hit[i] = 1'b1;
      if ((state_q[i] == ST_PEND || state_q[i] == ST_SENT) && addr_q[i] == wr_word) hazard = 1'b1;
      if (state_q[i] != ST_FREE && addr_q[i] == rd_word) rd_hit = 1'b1;
      if (state_q[i] != ST_FREE) all_free = 1'b0;
      if (state_q[i] == ST_FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = ID_WIDTH'(i);
      end
    end
  end

  assign wr_ready = !bus.flush_i && !hazard && ((|open_hit) || free_found);
  assign accept   = bus.wr_valid_i && wr_ready;
  assign alloc    = accept && !(|open_hit);
  assign head_idx = fifo_q[head_q];

  // An open entry closes on flush or on idle expiry, unless a merge lands on it.
  always_comb begin
    expire = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      expire[i] = (state_q[i] == ST_OPEN) &&
                  (bus.flush_i || (timer_q[i] == TIMER_MAX && !(accept && open_hit[i])));
    end
  end

`ifdef CVA6_HPDCACHE_WBUF_FEEDTHROUGH_EN
  assign req_valid = (count_q != '0) && (state_q[head_idx] == ST_PEND || expire[head_idx]);
`else
  assign req_valid = (count_q != '0) && (state_q[head_idx] == ST_PEND);
`endif
  assign fire = req_valid && bus.mem_req_ready_i;

  // Per-entry next state: allocate, merge, age, close, send, free on ack.
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      state_d[i] = state_q[i];
      addr_d[i]  = addr_q[i];
      data_d[i]  = data_q[i];
      be_d[i]    = be_q[i];
      timer_d[i] = timer_q[i];
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      case (state_q[i])
        ST_FREE: begin
          if (alloc && free_idx == ID_WIDTH'(i)) begin
            state_d[i] = ST_OPEN;
            addr_d[i]  = wr_word;
            data_d[i]  = merge_bytes('0, bus.wr_data_i, bus.wr_be_i);
            be_d[i]    = bus.wr_be_i;
            timer_d[i] = '0;
          end
        end
        ST_OPEN: begin
          if (accept && open_hit[i]) begin
            data_d[i]  = merge_bytes(data_q[i], bus.wr_data_i, bus.wr_be_i);
            be_d[i]    = be_q[i] | bus.wr_be_i;
            timer_d[i] = '0;
          end else if (expire[i]) begin
            state_d[i] = ST_PEND;
          end else begin
            timer_d[i] = timer_q[i] + TIMECNT_WIDTH'(1);
          end
        end
        ST_PEND: ;
        ST_SENT: begin
          if (bus.mem_rsp_valid_i && bus.mem_rsp_id_i == ID_WIDTH'(i)) state_d[i] = ST_FREE;
        end
      endcase
      if (fire && head_idx == ID_WIDTH'(i)) state_d[i] = ST_SENT;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        be_q[i]    <= '0;
        timer_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      timer_q <= timer_d;
    end
  end

  // Allocation-order FIFO of entry indices; the head is the only send candidate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) fifo_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) begin
        fifo_q[tail_q] <= free_idx;
        tail_q         <= tail_q + ID_WIDTH'(1);
      end
      if (fire) head_q <= head_q + ID_WIDTH'(1);
      count_q <= count_q + CNT_WIDTH'(alloc) - CNT_WIDTH'(fire);
    end
  end

  assign bus.wr_ready_o      = wr_ready;
  assign bus.rd_hit_o        = rd_hit;
  assign bus.empty_o         = all_free;
  assign bus.mem_req_valid_o = req_valid;
  assign bus.mem_req_addr_o  = {addr_q[head_idx], {OFF_WIDTH{1'b0}}};
  assign bus.mem_req_data_o  = data_q[head_idx];
  assign bus.mem_req_be_o    = be_q[head_idx];
  assign bus.mem_req_id_o    = head_idx;
endmodule
